axi_dw_allocator: RTL and testbench



---
 rtl/axi_dw_allocator.sv | 136 +++++++++++++
 tb/tb_axi_dw_allocator.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dw_allocator.sv
// W-channel allocator for one master port: queues AW-granted port IDs in a small FIFO and
// forwards W beats from the port at the FIFO head until that burst's wlast is accepted.
module axi_dw_allocator #(
   parameter int AXI_DATA_W  = 64,
   parameter int AXI_USER_W  = 6,
   parameter int N_TARG_PORT = 7,
   parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
   parameter int FIFO_DEPTH  = 4,
   parameter int ID_W        = LOG_N_TARG + N_TARG_PORT
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push_ID_i,
   input  logic [ID_W-1:0]                      ID_i,
   output logic                                 grant_FIFO_ID_o,
   input  logic [N_TARG_PORT*AXI_DATA_W-1:0]    wdata_i,
   input  logic [N_TARG_PORT*AXI_DATA_W/8-1:0]  wstrb_i,
   input  logic [N_TARG_PORT-1:0]               wlast_i,
   input  logic [N_TARG_PORT*AXI_USER_W-1:0]    wuser_i,
   input  logic [N_TARG_PORT-1:0]               wvalid_i,
   output logic [N_TARG_PORT-1:0]               wready_o,
   output logic [AXI_DATA_W-1:0]                wdata_o,
   output logic [AXI_DATA_W/8-1:0]              wstrb_o,
   output logic                                 wlast_o,
   output logic [AXI_USER_W-1:0]                wuser_o,
   output logic                                 wvalid_o,
   input  logic                                 wready_i
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int STRB_W = AXI_DATA_W / 8;

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [ID_W-1:0]        id_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [7:0]             beat_cnt_q;
   state_t                 state_q, state_d;

   logic                   empty, push, pop, handshake;
   logic [ID_W-1:0]        head;
   logic [LOG_N_TARG-1:0]  head_bin;
   logic [N_TARG_PORT-1:0] head_oh;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign grant_FIFO_ID_o = (count_q != CNT_W'(FIFO_DEPTH));
   assign push            = push_ID_i & grant_FIFO_ID_o;
   assign empty           = (count_q == '0);
   assign head            = id_mem[rd_ptr_q];
   assign head_bin        = head[ID_W-1:N_TARG_PORT];
   assign head_oh         = head[N_TARG_PORT-1:0];

   // The mux selects by the binary half; the one-hot half only gates the per-port ready.
   always_comb begin
      // NOTE: every output gets a default first so no path through the block can infer a latch.
      wvalid_o = 1'b0;
      wdata_o  = '0;
      wstrb_o  = '0;
      wlast_o  = 1'b0;
      wuser_o  = '0;
      if (!empty) begin
         for (int i = 0; i < N_TARG_PORT; i++) begin
            if (head_bin == LOG_N_TARG'(i)) begin
               wvalid_o = wvalid_i[i];
               wdata_o  = wdata_i[i*AXI_DATA_W +: AXI_DATA_W];
               wstrb_o  = wstrb_i[i*STRB_W +: STRB_W];
               wlast_o  = wlast_i[i];
               wuser_o  = wuser_i[i*AXI_USER_W +: AXI_USER_W];
            end
         end
      end
   end

   assign wready_o  = head_oh & {N_TARG_PORT{~empty & wready_i}};
   assign handshake = wvalid_o & wready_i;
   assign pop       = handshake & wlast_o;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (count_d != '0) state_d = ACTIVE;
         ACTIVE:  if (pop && count_d == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         beat_cnt_q <= '0;
         state_q    <= IDLE;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_d;
         state_q <= state_d;
         if (pop)            beat_cnt_q <= '0;
         else if (handshake) beat_cnt_q <= beat_cnt_q + 8'd1;
      end
   end

   // NOTE: ID storage is not reset; the reset pointers and count make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push) id_mem[wr_ptr_q] <= ID_i;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (push)
            assert (ID_i[N_TARG_PORT-1:0] == (N_TARG_PORT'(1) << ID_i[ID_W-1:N_TARG_PORT]))
            else $error("pushed ID one-hot/binary mismatch: %h", ID_i);
         if (handshake && !pop)
            assert (beat_cnt_q != 8'hFF) else $error("beat_cnt overflow");
         assert (count_q <= CNT_W'(FIFO_DEPTH)) else $error("count out of range");
         assert ((state_q == ACTIVE) == !empty) else $error("burst state disagrees with FIFO count");
      end
   end

endmodule

// File: tb/tb_axi_dw_allocator.sv
// Bench for axi_dw_allocator: directed scenarios plus randomized traffic checked against a
// queue-based model of the granted-port order.
module tb_axi_dw_allocator;

   localparam int N     = 7;
   localparam int DW    = 64;
   localparam int UW    = 6;
   localparam int DEPTH = 4;
   localparam int IDW   = 10;

   logic            clk = 1'b0;
   logic            rst;
   logic            push_ID_i;
   logic [IDW-1:0]  ID_i;
   logic            grant_FIFO_ID_o;
   logic [N*DW-1:0] wdata_i;
   logic [N*DW/8-1:0] wstrb_i;
   logic [N-1:0]    wlast_i;
   logic [N*UW-1:0] wuser_i;
   logic [N-1:0]    wvalid_i;
   logic [N-1:0]    wready_o;
   logic [DW-1:0]   wdata_o;
   logic [DW/8-1:0] wstrb_o;
   logic            wlast_o;
   logic [UW-1:0]   wuser_o;
   logic            wvalid_o;
   logic            wready_i;

   int n_chk = 0;
   int n_err = 0;
   int q[$];
   int n_push = 0;
   int n_pop  = 0;

   axi_dw_allocator #(
      .AXI_DATA_W(DW), .AXI_USER_W(UW), .N_TARG_PORT(N), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .push_ID_i(push_ID_i), .ID_i(ID_i), .grant_FIFO_ID_o(grant_FIFO_ID_o),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wuser_i(wuser_i),
      .wvalid_i(wvalid_i), .wready_o(wready_o),
      .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wuser_o(wuser_o),
      .wvalid_o(wvalid_o), .wready_i(wready_i)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [IDW-1:0] mk_id(input int p);
      logic [2:0] b;
      logic [6:0] oh;
      b  = p[2:0];
      oh = 7'd1 << p;
      return {b, oh};
   endfunction

   function automatic logic [DW-1:0] pat(input int p, input int b);
      return 64'hA5A5_0000_0000_0000 | (64'(p) << 8) | 64'(b);
   endfunction

   task automatic idle();
      push_ID_i = 1'b0;
      ID_i      = '0;
      wdata_i   = '0;
      wstrb_i   = '0;
      wlast_i   = '0;
      wuser_i   = '0;
      wvalid_i  = '0;
      wready_i  = 1'b0;
   endtask

   task automatic set_beat(input int p, input int b, input bit last);
      wdata_i[p*DW +: DW] = pat(p, b);
      wvalid_i[p] = 1'b1;
      wlast_i[p]  = last;
   endtask

   // Advance one clock and move the order model: the head leaves on an accepted last beat,
   // a new ID joins only when the queue had room before the edge.
   task automatic tick();
      bit do_push, do_pop;
      int h, b;
      do_push = push_ID_i && (q.size() < DEPTH);
      b = int'(ID_i[IDW-1:N]);
      do_pop = 1'b0;
      if (q.size() > 0) begin
         h = q[0];
         do_pop = wvalid_i[h] && wready_i && wlast_i[h];
      end
      @(posedge clk);
      if (do_pop)  begin void'(q.pop_front()); n_pop++; end
      if (do_push) begin q.push_back(b); n_push++; end
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (grant_FIFO_ID_o !== 1'b1) begin n_err++; $display("FAIL reset_grant: got %b exp 1", grant_FIFO_ID_o); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (wvalid_o !== 1'b0) begin n_err++; $display("FAIL reset_wvalid: got %b exp 0", wvalid_o); end
      n_chk++; if (wready_o !== 7'd0) begin n_err++; $display("FAIL reset_wready: got %b exp 0", wready_o); end
      n_chk++; if (wdata_o !== 64'd0 || wlast_o !== 1'b0) begin n_err++; $display("FAIL reset_data: got %h/%b exp 0/0", wdata_o, wlast_o); end
      n_chk++; if (dut.count_q !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", dut.count_q); end
   endtask

   task automatic test_single_burst();
      idle();
      push_ID_i = 1'b1; ID_i = 10'h104;
      set_beat(2, 0, 1'b0); wready_i = 1'b1;
      #1;
      n_chk++; if (wvalid_o !== 1'b0) begin n_err++; $display("FAIL single_push_cycle_wvalid: got %b exp 0", wvalid_o); end
      n_chk++; if (wready_o !== 7'd0) begin n_err++; $display("FAIL single_push_cycle_wready: got %b exp 0", wready_o); end
      tick();
      push_ID_i = 1'b0;
      for (int b = 0; b < 4; b++) begin
         set_beat(2, b, b == 3);
         #1;
         n_chk++; if (wvalid_o !== 1'b1) begin n_err++; $display("FAIL single_wvalid beat %0d: got %b exp 1", b, wvalid_o); end
         n_chk++; if (wready_o !== 7'b0000100) begin n_err++; $display("FAIL single_wready beat %0d: got %b exp 0000100", b, wready_o); end
         n_chk++; if (wdata_o !== pat(2, b) || wlast_o !== (b == 3)) begin n_err++; $display("FAIL single_beat %0d: got %h/%b exp %h/%b", b, wdata_o, wlast_o, pat(2, b), b == 3); end
         tick();
      end
      n_chk++; if (dut.count_q !== 3'd0) begin n_err++; $display("FAIL single_count_after: got %0d exp 0", dut.count_q); end
   endtask

   task automatic test_back_to_back();
      idle();
      wready_i = 1'b1;
      push_ID_i = 1'b1; ID_i = 10'h104;
      set_beat(2, 0, 1'b0); set_beat(5, 0, 1'b0);
      #1;
      n_chk++; if (wvalid_o !== 1'b0) begin n_err++; $display("FAIL b2b_push_cycle_wvalid: got %b exp 0", wvalid_o); end
      tick();
      ID_i = 10'h2A0;
      #1;
      n_chk++; if (wready_o !== 7'b0000100 || wdata_o !== pat(2, 0)) begin n_err++; $display("FAIL b2b_p2_beat0: got %b/%h exp 0000100/%h", wready_o, wdata_o, pat(2, 0)); end
      tick();
      push_ID_i = 1'b0;
      set_beat(2, 1, 1'b1);
      #1;
      n_chk++; if (wready_o !== 7'b0000100 || wdata_o !== pat(2, 1) || wlast_o !== 1'b1) begin n_err++; $display("FAIL b2b_p2_beat1: got %b/%h/%b exp 0000100/%h/1", wready_o, wdata_o, wlast_o, pat(2, 1)); end
      tick();
      #1;
      n_chk++; if (wready_o !== 7'b0100000 || wdata_o !== pat(5, 0)) begin n_err++; $display("FAIL b2b_p5_beat0: got %b/%h exp 0100000/%h", wready_o, wdata_o, pat(5, 0)); end
      tick();
      set_beat(5, 1, 1'b1);
      #1;
      n_chk++; if (wready_o !== 7'b0100000 || wdata_o !== pat(5, 1) || wlast_o !== 1'b1) begin n_err++; $display("FAIL b2b_p5_beat1: got %b/%h/%b exp 0100000/%h/1", wready_o, wdata_o, wlast_o, pat(5, 1)); end
      tick();
      n_chk++; if (dut.count_q !== 3'd0) begin n_err++; $display("FAIL b2b_count_after: got %0d exp 0", dut.count_q); end
   endtask

   task automatic test_full();
      int ports[4] = '{0, 1, 3, 6};
      idle();
      foreach (ports[i]) begin
         push_ID_i = 1'b1; ID_i = mk_id(ports[i]);
         tick();
      end
      push_ID_i = 1'b0;
      #1;
      n_chk++; if (grant_FIFO_ID_o !== 1'b0) begin n_err++; $display("FAIL full_grant: got %b exp 0", grant_FIFO_ID_o); end
      n_chk++; if (dut.count_q !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d exp 4", dut.count_q); end
      push_ID_i = 1'b1; ID_i = mk_id(4);
      tick();
      push_ID_i = 1'b0;
      n_chk++; if (dut.count_q !== 3'd4) begin n_err++; $display("FAIL full_dropped_push: got count %0d exp 4", dut.count_q); end
      set_beat(0, 0, 1'b1); wready_i = 1'b1;
      #1;
      n_chk++; if (wready_o !== 7'b0000001 || grant_FIFO_ID_o !== 1'b0) begin n_err++; $display("FAIL full_pop_cycle: got %b/%b exp 0000001/0", wready_o, grant_FIFO_ID_o); end
      tick();
      idle();
      #1;
      n_chk++; if (grant_FIFO_ID_o !== 1'b1) begin n_err++; $display("FAIL full_grant_return: got %b exp 1", grant_FIFO_ID_o); end
      for (int i = 1; i < 4; i++) begin
         wvalid_i = '0; wlast_i = '0;
         set_beat(ports[i], 0, 1'b1); wready_i = 1'b1;
         #1;
         n_chk++; if (wready_o !== 7'(1 << ports[i])) begin n_err++; $display("FAIL full_drain_order %0d: got %b exp port %0d", i, wready_o, ports[i]); end
         tick();
      end
      idle();
      n_chk++; if (dut.count_q !== 3'd0) begin n_err++; $display("FAIL full_count_after: got %0d exp 0 (dropped ID must not appear)", dut.count_q); end
   endtask

   task automatic test_push_pop_wrap();
      idle();
      for (int k = 0; k < 2; k++) begin
         push_ID_i = 1'b1; ID_i = mk_id(k);
         tick();
      end
      for (int k = 2; k < 10; k++) begin
         int h;
         h = q[0];
         wvalid_i = '0; wlast_i = '0;
         push_ID_i = 1'b1; ID_i = mk_id(k % N);
         set_beat(h, k, 1'b1); wready_i = 1'b1;
         #1;
         n_chk++; if (wready_o !== 7'(1 << h) || wdata_o !== pat(h, k)) begin n_err++; $display("FAIL wrap_order id %0d: got %b/%h exp port %0d/%h", k, wready_o, wdata_o, h, pat(h, k)); end
         tick();
         n_chk++; if (dut.count_q !== 3'd2) begin n_err++; $display("FAIL wrap_count id %0d: got %0d exp 2", k, dut.count_q); end
         n_chk++; if (dut.wr_ptr_q !== 2'(n_push % DEPTH) || dut.rd_ptr_q !== 2'(n_pop % DEPTH)) begin n_err++; $display("FAIL wrap_ptrs id %0d: got wr %0d rd %0d exp %0d %0d", k, dut.wr_ptr_q, dut.rd_ptr_q, n_push % DEPTH, n_pop % DEPTH); end
      end
      push_ID_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         int h;
         h = q[0];
         wvalid_i = '0; wlast_i = '0;
         set_beat(h, 0, 1'b1); wready_i = 1'b1;
         #1;
         n_chk++; if (wready_o !== 7'(1 << h)) begin n_err++; $display("FAIL wrap_drain %0d: got %b exp port %0d", k, wready_o, h); end
         tick();
      end
      idle();
   endtask

   task automatic test_stall();
      idle();
      push_ID_i = 1'b1; ID_i = mk_id(3);
      tick();
      push_ID_i = 1'b0;
      set_beat(3, 0, 1'b0); wready_i = 1'b1;
      tick();
      set_beat(3, 1, 1'b0); wready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_chk++; if (wvalid_o !== 1'b1 || wdata_o !== pat(3, 1)) begin n_err++; $display("FAIL stall_hold %0d: got %b/%h exp 1/%h", c, wvalid_o, wdata_o, pat(3, 1)); end
         n_chk++; if (wready_o !== 7'd0) begin n_err++; $display("FAIL stall_wready %0d: got %b exp 0", c, wready_o); end
         tick();
         n_chk++; if (dut.beat_cnt_q !== 8'd1 || dut.count_q !== 3'd1) begin n_err++; $display("FAIL stall_state %0d: got beat_cnt %0d count %0d exp 1 1", c, dut.beat_cnt_q, dut.count_q); end
      end
      wready_i = 1'b1;
      tick();
      n_chk++; if (dut.beat_cnt_q !== 8'd2) begin n_err++; $display("FAIL stall_resume_beat_cnt: got %0d exp 2", dut.beat_cnt_q); end
      set_beat(3, 2, 1'b1);
      tick();
      n_chk++; if (dut.beat_cnt_q !== 8'd0 || dut.count_q !== 3'd0) begin n_err++; $display("FAIL stall_end: got beat_cnt %0d count %0d exp 0 0", dut.beat_cnt_q, dut.count_q); end
      idle();
   endtask

   task automatic test_reset_mid_burst();
      idle();
      for (int k = 0; k < 3; k++) begin
         push_ID_i = 1'b1; ID_i = mk_id(2 + 2 * k);
         tick();
      end
      push_ID_i = 1'b0;
      set_beat(2, 0, 1'b0); wready_i = 1'b1;
      tick();
      set_beat(2, 1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      n_chk++; if (grant_FIFO_ID_o !== 1'b1 || wvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_outputs: got grant %b wvalid %b exp 1 0", grant_FIFO_ID_o, wvalid_o); end
      n_chk++; if (wready_o !== 7'd0 || wdata_o !== 64'd0) begin n_err++; $display("FAIL rst_mid_route: got %b/%h exp 0/0", wready_o, wdata_o); end
      n_chk++; if (dut.count_q !== 3'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d exp 0", dut.count_q); end
      q.delete(); n_push = 0; n_pop = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle();
      @(posedge clk); #1;
      push_ID_i = 1'b1; ID_i = 10'h104;
      set_beat(2, 0, 1'b1); wready_i = 1'b1;
      #1;
      n_chk++; if (wvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_after_push_cycle: got %b exp 0", wvalid_o); end
      tick();
      push_ID_i = 1'b0;
      #1;
      n_chk++; if (wvalid_o !== 1'b1 || wready_o !== 7'b0000100 || wdata_o !== pat(2, 0)) begin n_err++; $display("FAIL rst_after_route: got %b/%b/%h exp 1/0000100/%h", wvalid_o, wready_o, wdata_o, pat(2, 0)); end
      tick();
      n_chk++; if (dut.count_q !== 3'd0) begin n_err++; $display("FAIL rst_after_count: got %0d exp 0", dut.count_q); end
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         logic         e_valid, e_last;
         logic [N-1:0] e_ready;
         logic [DW-1:0] e_data;
         logic [DW/8-1:0] e_strb;
         logic [UW-1:0] e_user;
         int h;
         push_ID_i = ($urandom_range(2) == 0) && (q.size() < DEPTH);
         ID_i      = mk_id($urandom_range(N - 1));
         for (int k = 0; k < N * DW / 32; k++) wdata_i[k*32 +: 32] = $urandom;
         wstrb_i  = {$urandom, $urandom};
         wuser_i  = {$urandom, $urandom};
         wvalid_i = 7'($urandom);
         wlast_i  = 7'($urandom) & 7'($urandom);
         wready_i = ($urandom_range(3) != 0);
         e_valid = 1'b0; e_last = 1'b0; e_ready = '0; e_data = '0; e_strb = '0; e_user = '0;
         if (q.size() > 0) begin
            h = q[0];
            e_valid = wvalid_i[h];
            e_last  = wlast_i[h];
            e_ready = wready_i ? 7'(1 << h) : 7'd0;
            e_data  = wdata_i[h*DW +: DW];
            e_strb  = wstrb_i[h*(DW/8) +: DW/8];
            e_user  = wuser_i[h*UW +: UW];
         end
         #1;
         n_chk++; if (grant_FIFO_ID_o !== (q.size() < DEPTH)) begin n_err++; $display("FAIL rand_grant c%0d: got %b exp %b", c, grant_FIFO_ID_o, q.size() < DEPTH); end
         n_chk++; if (wvalid_o !== e_valid || wready_o !== e_ready) begin n_err++; $display("FAIL rand_handshake c%0d: got %b/%b exp %b/%b", c, wvalid_o, wready_o, e_valid, e_ready); end
         n_chk++; if (wdata_o !== e_data || wstrb_o !== e_strb || wuser_o !== e_user || wlast_o !== e_last) begin n_err++; $display("FAIL rand_payload c%0d: got %h/%h/%h/%b exp %h/%h/%h/%b", c, wdata_o, wstrb_o, wuser_o, wlast_o, e_data, e_strb, e_user, e_last); end
         tick();
      end
      idle();
      wvalid_i = '1; wlast_i = '1; wready_i = 1'b1;
      for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) tick();
      idle();
      n_chk++; if (dut.count_q !== 3'(q.size())) begin n_err++; $display("FAIL rand_drain: got count %0d exp %0d", dut.count_q, q.size()); end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_back_to_back();
      test_full();
      test_push_pop_wrap();
      test_stall();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
